fwd_ctrl: RTL and testbench
===========================

FWD_CTRL -- requirements
Module: fwd_ctrl

Interface
REQ-001 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset; asynchronous, active-low.
REQ-003 pipe_adv  input  1  pipeline advances this cycle (ID->EX->ME->WB shift).
REQ-004 flush  input  1  kill the instruction leaving ID; a bubble enters EX.
REQ-005 id_valid  input  1  ID holds a real instruction.
REQ-006 id_rs1_addr, id_rs2_addr  input  5 each  ID source register indices.
REQ-007 id_rs1_ren, id_rs2_ren  input  1 each  ID instruction actually reads rs1/rs2.
REQ-008 id_rd_addr  input  5  ID destination index.
REQ-009 id_rd_wen  input  1  ID instruction writes rd.
REQ-010 id_is_load  input  1  ID instruction is a load (data available only in WB).
REQ-011 ex_rs1_src, ex_rs2_src  output  2 each  registered select for the EX-stage operand mux: 2'b00 EX (regfile value), 2'b01 ME (me_alu_result), 2'b10 WB (wb_rd_data); 2'b11 is never driven.
REQ-012 load_use_stall  output  1  combinational; ID must be held and a bubble inserted.

Function
REQ-013 The block SHALL hold three tracking slots (EX, ME, WB), each with valid, rd[4:0], wen and is_load.
REQ-014 pipe_adv=1: WB<=ME, ME<=EX, EX<=ID entry, unless replaced by a bubble per REQ-016/017.
REQ-015 pipe_adv=0: all slots and ex_rs*_src SHALL hold their values.
REQ-016 flush=1 with pipe_adv=1: EX<=bubble (valid=0), ex_rs1_src=ex_rs2_src=00; older slots still shift.
REQ-017 load_use_stall=1 with pipe_adv=1: EX<=bubble, selects<=00; ID is not consumed.
REQ-018 load_use_stall = id_valid & !flush & EX.valid & EX.wen & EX.is_load & EX.rd!=0 & ((id_rs1_ren & id_rs1_addr==EX.rd) | (id_rs2_ren & id_rs2_addr==EX.rd)).
REQ-019 Flush SHALL dominate stall; load_use_stall is 0 whenever flush=1.
REQ-020 On a normal advance, the select for each source (only when its ren=1 and addr!=0) is computed against the pre-shift slots: match EX slot (non-load, valid, wen) -> 01; else match ME slot (valid, wen) -> 10; else 00.
REQ-021 Priority: the youngest producer wins (EX-slot match over ME-slot match).
REQ-022 A load in the ME slot matching at advance SHALL select 10 (load data arrives via WB).
REQ-023 Register x0 SHALL never be forwarded nor cause a stall.
REQ-024 Selects SHALL be registered, valid during the whole EX cycle of the instruction they belong to; latency exactly one pipe_adv.
REQ-025 WB-slot producers are not forwarded; the register file provides write-first bypass for the ID-stage read.
REQ-026 Both sources SHALL be evaluated independently; rs1 and rs2 may select different stages in the same cycle.

Reset
REQ-027 While rst_n=0: all slot valids=0, rd/wen/is_load=0, ex_rs1_src=ex_rs2_src=00, load_use_stall=0 (all slots invalid).
REQ-028 Reset asserted mid-operation SHALL clear the slots immediately without waiting for clk; the first advance after release behaves as from an empty pipeline.

Verification
REQ-029 ADD x5 then ADD x6,x5,x5 back-to-back with pipe_adv=1 -> consumer EX cycle: ex_rs1_src=01, ex_rs2_src=01.
REQ-030 ADD x5, NOP, SUB x7,x1,x5 -> SUB EX cycle: ex_rs1_src=00, ex_rs2_src=10.
REQ-031 LW x8 followed by ADD x9,x8,x0 -> load_use_stall=1 for one cycle, bubble in EX, then ADD EX cycle: ex_rs1_src=10, ex_rs2_src=00.
REQ-032 ADD x3, ADD x3, then consumer of x3 -> select 01 (youngest producer); producer writing x0 then consumer of x0 -> select 00, no stall.
REQ-033 LW x8 in EX, consumer of x8 in ID, flush=1 -> load_use_stall=0, EX becomes bubble with selects 00; pipe_adv=0 for 3 cycles -> selects held.
REQ-034 rst_n pulled low between clock edges with all slots valid -> outputs 00/0 at once; after release, ADD x5 then use of x5 forwards 01 normally.

Source files
------------

// File: rtl/fwd_ctrl_if.sv
// fwd_ctrl_if: bundle between the decode/issue logic and the forwarding
// controller.
//   ID-side inputs   : pipe_adv, flush, id_valid, id_rs1/rs2_addr,
//                      id_rs1/rs2_ren, id_rd_addr, id_rd_wen, id_is_load
//   controller output: ex_rs1_src, ex_rs2_src (registered EX operand mux
//                      selects), load_use_stall (combinational),
//                      wb_valid/wb_rd/wb_wen/wb_is_load (WB tracking slot,
//                      for observing the retiring write)
// master = pipeline control driving ID info, slave = fwd_ctrl.
interface fwd_ctrl_if;
  logic       pipe_adv;
  logic       flush;
  logic       id_valid;
  logic [4:0] id_rs1_addr;
  logic [4:0] id_rs2_addr;
  logic       id_rs1_ren;
  logic       id_rs2_ren;
  logic [4:0] id_rd_addr;
  logic       id_rd_wen;
  logic       id_is_load;
  logic [1:0] ex_rs1_src;
  logic [1:0] ex_rs2_src;
  logic       load_use_stall;
  logic       wb_valid;
  logic [4:0] wb_rd;
  logic       wb_wen;
  logic       wb_is_load;

  modport master (
    output pipe_adv, flush, id_valid, id_rs1_addr, id_rs2_addr,
           id_rs1_ren, id_rs2_ren, id_rd_addr, id_rd_wen, id_is_load,
    input  ex_rs1_src, ex_rs2_src, load_use_stall,
           wb_valid, wb_rd, wb_wen, wb_is_load
  );

  modport slave (
    input  pipe_adv, flush, id_valid, id_rs1_addr, id_rs2_addr,
           id_rs1_ren, id_rs2_ren, id_rd_addr, id_rd_wen, id_is_load,
    output ex_rs1_src, ex_rs2_src, load_use_stall,
           wb_valid, wb_rd, wb_wen, wb_is_load
  );
endinterface

// File: rtl/fwd_ctrl.sv
// fwd_ctrl: operand-forwarding and load-use hazard controller for a
// 4-stage ID->EX->ME->WB pipeline.
//   clk   : pipeline clock
//   rst_n : asynchronous active-low reset
//   bus   : fwd_ctrl_if.slave (ID instruction info in, EX operand selects,
//           load-use stall and WB-slot observation out)
// Operand select encoding: 00 regfile, 01 ME result, 10 WB data.
module fwd_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  fwd_ctrl_if.slave    bus
);

  logic       r_ex_valid, r_ex_wen, r_ex_is_load;
  logic [4:0] r_ex_rd;
  logic       r_me_valid, r_me_wen, r_me_is_load;
  logic [4:0] r_me_rd;
  logic       r_wb_valid, r_wb_wen, r_wb_is_load;
  logic [4:0] r_wb_rd;
  logic [1:0] r_rs1_src, r_rs2_src;

  logic       w_stall;
  logic       w_bubble;
  logic [1:0] w_rs1_sel, w_rs2_sel;

  // Select for one source, evaluated against the slots before they shift.
  // A load still in EX cannot forward (that case stalls instead); a load in
  // ME will be in WB when the consumer executes, so it takes the WB path.
  function automatic logic [1:0] src_sel(
    input logic       ren,
    input logic [4:0] addr,
    input logic       ex_valid,
    input logic       ex_wen,
    input logic       ex_is_load,
    input logic [4:0] ex_rd,
    input logic       me_valid,
    input logic       me_wen,
    input logic [4:0] me_rd
  );
    src_sel = 2'b00;
    if (ren && (addr != 5'd0)) begin
      if (ex_valid && ex_wen && !ex_is_load && (ex_rd == addr))
        src_sel = 2'b01;
      else if (me_valid && me_wen && (me_rd == addr))
        src_sel = 2'b10;
    end
  endfunction

  always_comb begin
    w_stall = bus.id_valid & ~bus.flush & r_ex_valid & r_ex_wen &
              r_ex_is_load & (r_ex_rd != 5'd0) &
              ((bus.id_rs1_ren & (bus.id_rs1_addr == r_ex_rd)) |
               (bus.id_rs2_ren & (bus.id_rs2_addr == r_ex_rd)));
    w_bubble  = bus.flush | w_stall;
    w_rs1_sel = src_sel(bus.id_rs1_ren, bus.id_rs1_addr,
                        r_ex_valid, r_ex_wen, r_ex_is_load, r_ex_rd,
                        r_me_valid, r_me_wen, r_me_rd);
    w_rs2_sel = src_sel(bus.id_rs2_ren, bus.id_rs2_addr,
                        r_ex_valid, r_ex_wen, r_ex_is_load, r_ex_rd,
                        r_me_valid, r_me_wen, r_me_rd);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid   <= 1'b0;
      r_ex_wen     <= 1'b0;
      r_ex_is_load <= 1'b0;
      r_ex_rd      <= 5'd0;
      r_me_valid   <= 1'b0;
      r_me_wen     <= 1'b0;
      r_me_is_load <= 1'b0;
      r_me_rd      <= 5'd0;
      r_wb_valid   <= 1'b0;
      r_wb_wen     <= 1'b0;
      r_wb_is_load <= 1'b0;
      r_wb_rd      <= 5'd0;
      r_rs1_src    <= 2'b00;
      r_rs2_src    <= 2'b00;
    end else if (bus.pipe_adv) begin
      // ME -> WB boundary
      r_wb_valid   <= r_me_valid;
      r_wb_wen     <= r_me_wen;
      r_wb_is_load <= r_me_is_load;
      r_wb_rd      <= r_me_rd;
      // EX -> ME boundary
      r_me_valid   <= r_ex_valid;
      r_me_wen     <= r_ex_wen;
      r_me_is_load <= r_ex_is_load;
      r_me_rd      <= r_ex_rd;
      // ID -> EX boundary: flush or load-use hazard inserts a bubble
      if (w_bubble) begin
        r_ex_valid   <= 1'b0;
        r_ex_wen     <= 1'b0;
        r_ex_is_load <= 1'b0;
        r_ex_rd      <= 5'd0;
        r_rs1_src    <= 2'b00;
        r_rs2_src    <= 2'b00;
      end else begin
        r_ex_valid   <= bus.id_valid;
        r_ex_wen     <= bus.id_rd_wen;
        r_ex_is_load <= bus.id_is_load;
        r_ex_rd      <= bus.id_rd_addr;
        r_rs1_src    <= w_rs1_sel;
        r_rs2_src    <= w_rs2_sel;
      end
    end
  end

  assign bus.ex_rs1_src     = r_rs1_src;
  assign bus.ex_rs2_src     = r_rs2_src;
  assign bus.load_use_stall = w_stall;
  assign bus.wb_valid       = r_wb_valid;
  assign bus.wb_rd          = r_wb_rd;
  assign bus.wb_wen         = r_wb_wen;
  assign bus.wb_is_load     = r_wb_is_load;

endmodule

// File: tb/tb_fwd_ctrl.sv
// tb_fwd_ctrl: directed bench for fwd_ctrl. Expected selects are queued when
// an instruction is advanced into EX and compared once the DUT registers them.
module tb_fwd_ctrl;

  logic clk;
  logic rst_n;
  fwd_ctrl_if ifc ();

  fwd_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         checks;
  int         errors;
  logic [3:0] sb[$];
  logic [3:0] last_exp;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_id(input logic v,
                          input logic [4:0] rs1, input logic r1en,
                          input logic [4:0] rs2, input logic r2en,
                          input logic [4:0] rd, input logic wen, input logic ld);
    ifc.id_valid    = v;
    ifc.id_rs1_addr = rs1;
    ifc.id_rs1_ren  = r1en;
    ifc.id_rs2_addr = rs2;
    ifc.id_rs2_ren  = r2en;
    ifc.id_rd_addr  = rd;
    ifc.id_rd_wen   = wen;
    ifc.id_is_load  = ld;
  endtask

  // One clock: stall checked mid-cycle, selects checked just after the edge.
  task automatic cyc(input string tag, input logic adv, input logic fl,
                     input logic exp_stall, input logic [1:0] e1, input logic [1:0] e2);
    ifc.pipe_adv = adv;
    ifc.flush    = fl;
    @(negedge clk);
    chk({tag, "_stall"}, {7'd0, ifc.load_use_stall}, {7'd0, exp_stall});
    if (adv) sb.push_back({e1, e2});
    @(posedge clk);
    #1;
    if (adv) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL %s_sb observed=empty expected=entry", tag);
      end else begin
        last_exp = sb.pop_front();
      end
    end
    chk({tag, "_rs1"}, {6'd0, ifc.ex_rs1_src}, {6'd0, last_exp[3:2]});
    chk({tag, "_rs2"}, {6'd0, ifc.ex_rs2_src}, {6'd0, last_exp[1:0]});
    ifc.pipe_adv = 1'b0;
    ifc.flush    = 1'b0;
  endtask

  task automatic ins(input string tag, input logic v,
                     input logic [4:0] rs1, input logic r1en,
                     input logic [4:0] rs2, input logic r2en,
                     input logic [4:0] rd, input logic wen, input logic ld,
                     input logic [1:0] e1, input logic [1:0] e2);
    drive_id(v, rs1, r1en, rs2, r2en, rd, wen, ld);
    cyc(tag, 1'b1, 1'b0, 1'b0, e1, e2);
  endtask

  task automatic drain();
    ins("drain0", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00);
    ins("drain1", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    last_exp = 4'h0;
    rst_n    = 1'b0;
    ifc.pipe_adv = 1'b0;
    ifc.flush    = 1'b0;
    drive_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rs1", {6'd0, ifc.ex_rs1_src}, 8'h00);
    chk("rst_rs2", {6'd0, ifc.ex_rs2_src}, 8'h00);
    chk("rst_stall", {7'd0, ifc.load_use_stall}, 8'h00);
    chk("rst_wbv", {7'd0, ifc.wb_valid}, 8'h00);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ADD x5 ; ADD x6,x5,x5 -> EX forwarding on both sources
    ins("add5",   1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 2'b00, 2'b00);
    ins("add6",   1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0, 2'b01, 2'b01);

    // ADD x5 ; NOP ; SUB x7,x1,x5 -> rs2 from WB path
    ins("add5b",  1'b1, 5'd10, 1'b1, 5'd11, 1'b1, 5'd5, 1'b1, 1'b0, 2'b00, 2'b00);
    ins("nop",    1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 2'b00, 2'b00);
    ins("sub7",   1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0, 2'b00, 2'b10);

    // LW x8 ; ADD x9,x8,x0 -> one stall cycle, then rs1 from WB path
    drain();
    ins("lw8",    1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 2'b00, 2'b00);
    drive_id(1'b1, 5'd8, 1'b1, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0);
    cyc("luse_bub", 1'b1, 1'b0, 1'b1, 2'b00, 2'b00);
    cyc("luse_add", 1'b1, 1'b0, 1'b0, 2'b10, 2'b00);

    // Youngest producer wins, then select hold with pipe_adv=0
    drain();
    ins("add3a",  1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 2'b00, 2'b00);
    ins("add3b",  1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 2'b00, 2'b00);
    ins("add4",   1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0, 2'b01, 2'b01);
    for (int i = 0; i < 3; i++) cyc("hold01", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);

    // x0 is never forwarded and never stalls
    ins("addx0",  1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 2'b00, 2'b00);
    ins("usex0",  1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd1, 1'b1, 1'b0, 2'b00, 2'b00);
    ins("lwx0",   1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 2'b00, 2'b00);
    ins("uselx0", 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd2, 1'b1, 1'b0, 2'b00, 2'b00);

    // Independent sources: rs1 from EX, rs2 from ME
    drain();
    ins("add10",  1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd10, 1'b1, 1'b0, 2'b00, 2'b00);
    ins("add11",  1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd11, 1'b1, 1'b0, 2'b00, 2'b00);
    ins("add12",  1'b1, 5'd11, 1'b1, 5'd10, 1'b1, 5'd12, 1'b1, 1'b0, 2'b01, 2'b10);

    // Flush dominates a load-use hazard; selects then hold at 00
    drain();
    ins("lw8f",   1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 2'b00, 2'b00);
    drive_id(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
    cyc("flush", 1'b1, 1'b1, 1'b0, 2'b00, 2'b00);
    for (int i = 0; i < 3; i++) cyc("hold00", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);

    // Stall is visible while the pipe is frozen, then resolves normally
    ins("lw8s",   1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 2'b00, 2'b00);
    drive_id(1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 5'd9, 1'b1, 1'b0);
    cyc("stall_frz", 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
    cyc("stall_bub", 1'b1, 1'b0, 1'b1, 2'b00, 2'b00);
    cyc("stall_use", 1'b1, 1'b0, 1'b0, 2'b00, 2'b10);

    // Asynchronous reset with all slots valid
    drain();
    ins("r_add5", 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 2'b00, 2'b00);
    ins("r_add6", 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0, 2'b01, 2'b01);
    ins("r_lw8",  1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 2'b01, 2'b00);
    chk("wb_valid", {7'd0, ifc.wb_valid}, 8'h01);
    chk("wb_rd", {3'd0, ifc.wb_rd}, 8'h05);
    drive_id(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
    #2;
    chk("pre_rst_stall", {7'd0, ifc.load_use_stall}, 8'h01);
    rst_n = 1'b0;
    #1;
    chk("arst_rs1", {6'd0, ifc.ex_rs1_src}, 8'h00);
    chk("arst_rs2", {6'd0, ifc.ex_rs2_src}, 8'h00);
    chk("arst_stall", {7'd0, ifc.load_use_stall}, 8'h00);
    chk("arst_wbv", {7'd0, ifc.wb_valid}, 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.delete();
    last_exp = 4'h0;
    ins("p_add5", 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 2'b00, 2'b00);
    ins("p_add6", 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0, 2'b01, 2'b01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
